// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and its datapath.
// Instruction fields and ALU flags flow in; enables and selects flow out.
interface multicycle_ctrl_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       V;
  logic       N;
  logic       C;
  logic       PCWrite;
  logic       AdrSrc;
  logic       IRWrite;
  logic       MemWrite;
  logic       RegWrite;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [2:0] ImmSrc;
  logic [3:0] ALUControl;
  logic       Retire;
  logic [3:0] State;

  modport master (
    input  op, funct3, funct7b5,
    input  Zero, V, N, C,
    output PCWrite, AdrSrc, IRWrite,
    output MemWrite, RegWrite,
    output ALUSrcA, ALUSrcB, ResultSrc,
    output ImmSrc, ALUControl,
    output Retire, State
  );

  modport slave (
    output op, funct3, funct7b5,
    output Zero, V, N, C,
    input  PCWrite, AdrSrc, IRWrite,
    input  MemWrite, RegWrite,
    input  ALUSrcA, ALUSrcB, ResultSrc,
    input  ImmSrc, ALUControl,
    input  Retire, State
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I main controller: state machine plus ALU,
// branch and immediate decode; outputs are Moore-decoded per state.
module multicycle_ctrl #(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11,
    S_AUIPC    = 4'd12,
    S_ERROR    = 4'd15
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;

  state_t     state_q;
  state_t     state_d;
  state_t     out_st;
  logic       legal;
  logic       taken;
  logic [3:0] alu_fn;

  // Opcode classification for DECODE dispatch.
  always_comb begin
    legal = 1'b1;
    case (bus.op)
      7'b0000011, 7'b0100011,
      7'b0110011, 7'b0010011,
      7'b1100011, 7'b1101111,
      7'b0110111, 7'b0010111: legal = 1'b1;
      default:                legal = 1'b0;
    endcase
  end

  // Next-state logic; unused codes fall back to FETCH.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          7'b0000011,
          7'b0100011: state_d = S_MEMADR;
          7'b0110011: state_d = S_EXECR;
          7'b0010011: state_d = S_EXECI;
          7'b1100011: state_d = S_BRANCH;
          7'b1101111: state_d = S_JAL;
          7'b0110111: state_d = S_LUI;
          7'b0010111: state_d = S_AUIPC;
          default:
            state_d = HALT_ON_ILLEGAL ?
                      S_ERROR : S_FETCH;
        endcase
      end
      S_MEMADR:
        state_d = bus.op[5] ? S_MEMWRITE
                            : S_MEMREAD;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECR,
      S_EXECI,
      S_JAL,
      S_LUI,
      S_AUIPC:    state_d = S_ALUWB;
      S_MEMWB,
      S_MEMWRITE,
      S_ALUWB,
      S_BRANCH:   state_d = S_FETCH;
      S_ERROR:    state_d = S_ERROR;
      default:    state_d = S_FETCH;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // ALU operation from funct fields (R-type and I-type).
  always_comb begin
    alu_fn = ALU_ADD;
    case (bus.funct3)
      3'b000: alu_fn = (bus.funct7b5 & bus.op[5])
                       ? ALU_SUB : ALU_ADD;
      3'b001: alu_fn = 4'b0110;
      3'b010: alu_fn = 4'b0101;
      3'b011: alu_fn = 4'b1001;
      3'b100: alu_fn = 4'b0100;
      3'b101: alu_fn = bus.funct7b5
                       ? 4'b0111 : 4'b1000;
      3'b110: alu_fn = 4'b0011;
      3'b111: alu_fn = 4'b0010;
      default: alu_fn = ALU_ADD;
    endcase
  end

  // Branch condition from the current-cycle flags.
  always_comb begin
    taken = 1'b0;
    case (bus.funct3)
      3'b000: taken = bus.Zero;
      3'b001: taken = ~bus.Zero;
      3'b100: taken = bus.N ^ bus.V;
      3'b101: taken = ~(bus.N ^ bus.V);
      3'b110: taken = ~bus.C;
      3'b111: taken = bus.C;
      default: taken = 1'b0;
    endcase
  end

  // Immediate format select, independent of state.
  always_comb begin
    bus.ImmSrc = 3'b000;
    case (bus.op)
      7'b0100011: bus.ImmSrc = 3'b001;
      7'b1100011: bus.ImmSrc = 3'b010;
      7'b1101111: bus.ImmSrc = 3'b011;
      7'b0110111,
      7'b0010111: bus.ImmSrc = 3'b100;
      default:    bus.ImmSrc = 3'b000;
    endcase
  end

  // Per-state outputs; reset decodes as FETCH with enables off.
  always_comb begin
    out_st         = reset ? S_FETCH : state_q;
    bus.PCWrite    = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.ALUSrcA    = 2'b00;
    bus.ALUSrcB    = 2'b00;
    bus.ResultSrc  = 2'b00;
    bus.ALUControl = ALU_ADD;
    bus.Retire     = 1'b0;
    case (out_st)
      S_FETCH: begin
        bus.IRWrite   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        bus.PCWrite   = 1'b1;
      end
      S_DECODE: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b01;
        bus.Retire  = ~legal & ~HALT_ON_ILLEGAL;
      end
      S_MEMADR: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
      end
      S_MEMREAD: bus.AdrSrc = 1'b1;
      S_MEMWRITE: begin
        bus.AdrSrc   = 1'b1;
        bus.MemWrite = 1'b1;
        bus.Retire   = 1'b1;
      end
      S_MEMWB: begin
        bus.ResultSrc = 2'b01;
        bus.RegWrite  = 1'b1;
        bus.Retire    = 1'b1;
      end
      S_EXECR: begin
        bus.ALUSrcA    = 2'b10;
        bus.ALUControl = alu_fn;
      end
      S_EXECI: begin
        bus.ALUSrcA    = 2'b10;
        bus.ALUSrcB    = 2'b01;
        bus.ALUControl = alu_fn;
      end
      S_ALUWB: begin
        bus.RegWrite = 1'b1;
        bus.Retire   = 1'b1;
      end
      S_BRANCH: begin
        bus.ALUSrcA    = 2'b10;
        bus.ALUControl = ALU_SUB;
        bus.PCWrite    = taken;
        bus.Retire     = 1'b1;
      end
      S_JAL: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b10;
        bus.PCWrite = 1'b1;
      end
      S_LUI: begin
        bus.ALUSrcA = 2'b11;
        bus.ALUSrcB = 2'b01;
      end
      S_AUIPC: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b01;
      end
      default: ;
    endcase
    if (reset) begin
      bus.PCWrite  = 1'b0;
      bus.IRWrite  = 1'b0;
      bus.MemWrite = 1'b0;
      bus.RegWrite = 1'b0;
      bus.Retire   = 1'b0;
    end
  end

  assign bus.State = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: two instances (halt and no-halt
// on illegal ops) checked cycle by cycle through a scoreboard queue.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       adr;
    logic       irw;
    logic       mw;
    logic       rw;
    logic       ret;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] rs;
    logic [2:0] imm;
    logic [3:0] alu;
  } exp_t;

  typedef struct {
    exp_t e;
    bit   d;
    int   tid;
    int   cyc;
  } item_t;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic [2:0] f3;
  logic       f7;
  logic       zf, vf, nf, cf;
  int         tid;
  int         cnum;
  int         checks;
  int         errors;
  bit         done;
  item_t      q[$];

  multicycle_ctrl_if b0 ();
  multicycle_ctrl_if b1 ();

  assign b0.op = op;
  assign b0.funct3 = f3;
  assign b0.funct7b5 = f7;
  assign b0.Zero = zf;
  assign b0.V = vf;
  assign b0.N = nf;
  assign b0.C = cf;
  assign b1.op = op;
  assign b1.funct3 = f3;
  assign b1.funct7b5 = f7;
  assign b1.Zero = zf;
  assign b1.V = vf;
  assign b1.N = nf;
  assign b1.C = cf;

  multicycle_ctrl #(.HALT_ON_ILLEGAL(1'b1)) u0 (
    .clk(clk), .reset(reset), .bus(b0)
  );
  multicycle_ctrl #(.HALT_ON_ILLEGAL(1'b0)) u1 (
    .clk(clk), .reset(reset), .bus(b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t act0();
    return {b0.State, b0.PCWrite, b0.AdrSrc,
            b0.IRWrite, b0.MemWrite, b0.RegWrite,
            b0.Retire, b0.ALUSrcA, b0.ALUSrcB,
            b0.ResultSrc, b0.ImmSrc, b0.ALUControl};
  endfunction

  function automatic exp_t act1();
    return {b1.State, b1.PCWrite, b1.AdrSrc,
            b1.IRWrite, b1.MemWrite, b1.RegWrite,
            b1.Retire, b1.ALUSrcA, b1.ALUSrcB,
            b1.ResultSrc, b1.ImmSrc, b1.ALUControl};
  endfunction

  function automatic exp_t mk(
    input logic [3:0] st, input logic [2:0] im,
    input logic [3:0] fn, input logic tk,
    input logic rs_on, input logic ill_ret);
    exp_t e;
    logic [3:0] ds;
    e = '0;
    e.st = st;
    e.imm = im;
    ds = rs_on ? 4'd0 : st;
    case (ds)
      4'd0: begin
        e.irw = 1; e.sb = 2'b10;
        e.rs = 2'b10; e.pcw = 1;
      end
      4'd1: begin
        e.sa = 2'b01; e.sb = 2'b01;
        e.ret = ill_ret;
      end
      4'd2: begin e.sa = 2'b10; e.sb = 2'b01; end
      4'd3: e.adr = 1;
      4'd4: begin
        e.rs = 2'b01; e.rw = 1; e.ret = 1;
      end
      4'd5: begin
        e.adr = 1; e.mw = 1; e.ret = 1;
      end
      4'd6: begin e.sa = 2'b10; e.alu = fn; end
      4'd7: begin
        e.sa = 2'b10; e.sb = 2'b01; e.alu = fn;
      end
      4'd8: begin e.rw = 1; e.ret = 1; end
      4'd9: begin
        e.sa = 2'b10; e.alu = 4'b0001;
        e.pcw = tk; e.ret = 1;
      end
      4'd10: begin
        e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1;
      end
      4'd11: begin e.sa = 2'b11; e.sb = 2'b01; end
      4'd12: begin e.sa = 2'b01; e.sb = 2'b01; end
      default: ;
    endcase
    if (rs_on) begin
      e.pcw = 0; e.irw = 0; e.mw = 0;
      e.rw = 0; e.ret = 0;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    item_t it;
    exp_t a;
    while (q.size() > 0) begin
      it = q.pop_front();
      a = it.d ? act1() : act0();
      checks++;
      if (a !== it.e) begin
        errors++;
        $display("FAIL t%0d c%0d dut%0d got %h exp %h",
                 it.tid, it.cyc, it.d, a, it.e);
      end
    end
  end

  initial begin
    #20000;
    if (!done) begin
      errors++;
      $display("FAIL timeout: sequence did not finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  task automatic cyc(input exp_t e0, input exp_t e1,
                     input bit c1);
    item_t it;
    it.tid = tid;
    it.cyc = cnum;
    it.e = e0;
    it.d = 1'b0;
    q.push_back(it);
    if (c1) begin
      it.e = e1;
      it.d = 1'b1;
      q.push_back(it);
    end
    cnum++;
    @(posedge clk);
    #1;
  endtask

  task automatic instr(
    input int t, input logic [6:0] o,
    input logic [2:0] fu3, input logic fu7,
    input logic [2:0] im, input logic [3:0] fn,
    input logic tk, input logic [3:0] s2,
    input logic [3:0] s3, input logic [3:0] s4,
    input int n);
    logic [3:0] sl [5];
    exp_t e;
    tid = t; cnum = 0;
    op = o; f3 = fu3; f7 = fu7;
    sl[0] = 4'd0; sl[1] = 4'd1;
    sl[2] = s2; sl[3] = s3; sl[4] = s4;
    for (int i = 0; i < n; i++) begin
      e = mk(sl[i], im, fn, tk, 1'b0, 1'b0);
      cyc(e, e, 1'b1);
    end
  endtask

  initial begin
    exp_t e, e1;
    checks = 0; errors = 0; done = 0;
    tid = 0; cnum = 0;
    op = '0; f3 = '0; f7 = 0;
    zf = 0; vf = 0; nf = 0; cf = 0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (b0.State !== 4'd0 || b1.State !== 4'd0 ||
        b0.PCWrite !== 1'b0 || b0.IRWrite !== 1'b0 ||
        b0.MemWrite !== 1'b0 || b0.RegWrite !== 1'b0 ||
        b0.Retire !== 1'b0) begin
      errors++;
      $display("FAIL reset state st%0d/%0d",
               b0.State, b1.State);
    end
    e = mk(4'd0, 3'b000, 4'd0, 0, 1, 0);
    cyc(e, e, 1'b1);
    reset = 1'b0;

    instr(1, 7'b0000011, 3'b010, 0, 3'b000,
          4'b0000, 0, 4'd2, 4'd3, 4'd4, 5);
    instr(2, 7'b0110011, 3'b000, 1, 3'b000,
          4'b0001, 0, 4'd6, 4'd8, 4'd0, 4);
    instr(3, 7'b0010011, 3'b101, 1, 3'b000,
          4'b0111, 0, 4'd7, 4'd8, 4'd0, 4);
    instr(4, 7'b0010011, 3'b000, 1, 3'b000,
          4'b0000, 0, 4'd7, 4'd8, 4'd0, 4);
    instr(5, 7'b0110011, 3'b101, 0, 3'b000,
          4'b1000, 0, 4'd6, 4'd8, 4'd0, 4);
    instr(6, 7'b0110011, 3'b011, 0, 3'b000,
          4'b1001, 0, 4'd6, 4'd8, 4'd0, 4);
    instr(7, 7'b0010011, 3'b111, 0, 3'b000,
          4'b0010, 0, 4'd7, 4'd8, 4'd0, 4);

    cf = 0;
    instr(8, 7'b1100011, 3'b110, 0, 3'b010,
          4'd0, 1, 4'd9, 4'd0, 4'd0, 3);
    cf = 1;
    instr(9, 7'b1100011, 3'b110, 0, 3'b010,
          4'd0, 0, 4'd9, 4'd0, 4'd0, 3);
    cf = 0; zf = 1;
    instr(10, 7'b1100011, 3'b000, 0, 3'b010,
          4'd0, 1, 4'd9, 4'd0, 4'd0, 3);
    instr(11, 7'b1100011, 3'b001, 0, 3'b010,
          4'd0, 0, 4'd9, 4'd0, 4'd0, 3);
    zf = 0; nf = 1; vf = 0;
    instr(12, 7'b1100011, 3'b100, 0, 3'b010,
          4'd0, 1, 4'd9, 4'd0, 4'd0, 3);
    instr(13, 7'b1100011, 3'b011, 0, 3'b010,
          4'd0, 0, 4'd9, 4'd0, 4'd0, 3);
    nf = 0;

    instr(14, 7'b1101111, 3'b000, 0, 3'b011,
          4'd0, 0, 4'd10, 4'd8, 4'd0, 4);
    instr(15, 7'b0110111, 3'b000, 0, 3'b100,
          4'd0, 0, 4'd11, 4'd8, 4'd0, 4);
    instr(16, 7'b0010111, 3'b000, 0, 3'b100,
          4'd0, 0, 4'd12, 4'd8, 4'd0, 4);

    instr(17, 7'b0100011, 3'b010, 0, 3'b001,
          4'd0, 0, 4'd2, 4'd0, 4'd0, 3);
    reset = 1'b1;
    e = mk(4'd5, 3'b001, 4'd0, 0, 1, 0);
    cyc(e, e, 1'b1);
    reset = 1'b0;
    instr(18, 7'b0100011, 3'b010, 0, 3'b001,
          4'd0, 0, 4'd2, 4'd5, 4'd0, 4);

    tid = 19; cnum = 0;
    op = 7'b1111111; f3 = 3'b000; f7 = 0;
    e = mk(4'd0, 3'b000, 4'd0, 0, 0, 0);
    cyc(e, e, 1'b1);
    e = mk(4'd1, 3'b000, 4'd0, 0, 0, 0);
    e1 = mk(4'd1, 3'b000, 4'd0, 0, 0, 1);
    cyc(e, e1, 1'b1);
    e = mk(4'd15, 3'b000, 4'd0, 0, 0, 0);
    e1 = mk(4'd0, 3'b000, 4'd0, 0, 0, 0);
    cyc(e, e1, 1'b1);
    for (int i = 0; i < 11; i++) cyc(e, e, 1'b0);
    reset = 1'b1;
    e = mk(4'd15, 3'b000, 4'd0, 0, 1, 0);
    cyc(e, e, 1'b0);
    reset = 1'b0;
    instr(20, 7'b0110111, 3'b000, 0, 3'b100,
          4'd0, 0, 4'd11, 4'd8, 4'd0, 4);

    @(negedge clk);
    #1;
    done = 1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter HALT_ON_ILLEGAL, default 1: 1 = an unsupported opcode enters the sticky ERROR state; 0 = it is treated as a 2-cycle no-op.
REQ-002 clk  in  1  the single clock; all state changes occur on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 op  in  7  opcode, Instr[6:0], from the instruction register.
REQ-005 funct3  in  3  Instr[14:12].
REQ-006 funct7b5  in  1  Instr[30].
REQ-007 Zero, V, N, C  in  1 each  ALU flags of the current cycle.
REQ-008 PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite  out  1 each  datapath enables and selects.
REQ-009 ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1 register A, 11 constant zero.
REQ-010 ALUSrcB  out  2  00 rs2 register, 01 ImmExt, 10 constant 4.
REQ-011 ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult.
REQ-012 ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
REQ-013 ALUControl  out  4  uses the single-cycle ALU encoding: add 0000, sub 0001, and 0010, or 0011, xor 0100, slt 0101, sll 0110, sra 0111, srl 1000, sltu 1001.
REQ-014 Retire  out  1  one-cycle pulse on the final cycle of every completed instruction.
REQ-015 State  out  4  current state code, for debug.

Function
REQ-016 State codes SHALL be: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BRANCH 9, JAL 10, LUI 11, AUIPC 12, ERROR 15; codes 13 and 14 SHALL go to FETCH.
REQ-017 Transitions SHALL be:
- FETCH -> DECODE.
- DECODE -> MEMADR for op 0000011 or 0100011; EXECUTER for 0110011; EXECUTEI for 0010011; BRANCH for 1100011; JAL for 1101111; LUI for 0110111; AUIPC for 0010111.
- DECODE with any other op -> ERROR if HALT_ON_ILLEGAL=1, else FETCH with Retire=1.
- MEMADR -> MEMREAD when op[5]=0, else MEMWRITE.
- MEMREAD -> MEMWB.
- EXECUTER, EXECUTEI, JAL, LUI, AUIPC -> ALUWB.
- MEMWB, MEMWRITE, ALUWB, BRANCH -> FETCH.
- ERROR -> ERROR until reset.
REQ-018 Any output not listed for a state in REQ-019 SHALL be 0.
REQ-019 Per-state outputs SHALL be:
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10, PCWrite=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (computes the branch/jal target into ALUOut).
- MEMADR: ALUSrcA=10, ALUSrcB=01, add.
- MEMREAD: ResultSrc=00, AdrSrc=1.
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1.
- MEMWB: ResultSrc=01, RegWrite=1.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, funct decode.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, funct decode.
- ALUWB: ResultSrc=00, RegWrite=1.
- BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, PCWrite=taken.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1.
- LUI: ALUSrcA=11, ALUSrcB=01, add.
- AUIPC: ALUSrcA=01, ALUSrcB=01, add.
- ERROR: all enables 0.
REQ-020 Funct decode:
- funct3 000: sub if funct7b5 & op[5], else add.
- 001: sll. 010: slt. 011: sltu. 100: xor.
- 101: sra if funct7b5, else srl.
- 110: or. 111: and.
REQ-021 The branch taken term SHALL be combinational on the flags of the BRANCH cycle:
- funct3 000: Zero. 001: ~Zero.
- 100: N^V. 101: ~(N^V).
- 110: ~C. 111: C.
- 010 and 011: 0.
REQ-022 ImmSrc SHALL be decoded from op in every state: 0100011 -> 001; 1100011 -> 010; 1101111 -> 011; 0110111 and 0010111 -> 100; otherwise 000.
REQ-023 Retire SHALL be 1 exactly in MEMWB, MEMWRITE, ALUWB, BRANCH, and the illegal-op DECODE cycle when HALT_ON_ILLEGAL=0.
REQ-024 Latency in cycles SHALL be: lw 5; sw, R-type, I-type, jal, lui, auipc 4; branch 3.

Reset
REQ-025 A clock edge with reset=1 SHALL set State to FETCH from any state, including ERROR and mid-instruction states.
REQ-026 While reset=1, PCWrite, IRWrite, MemWrite, RegWrite and Retire SHALL be forced to 0; all other outputs follow the FETCH state.
REQ-027 The first cycle after reset deasserts SHALL be FETCH with IRWrite=1 and PCWrite=1.

Verification
REQ-028 lw (op 0000011) after reset -> State sequence 0,1,2,3,4,0; RegWrite=1 only in state 4; Retire=1 only in state 4.
REQ-029 sub (op 0110011, funct3 000, funct7b5 1) -> EXECUTER drives ALUControl=0001, then ALUWB drives RegWrite=1; srai (op 0010011, funct3 101, funct7b5 1) -> ALUControl=0111.
REQ-030 bltu (op 1100011, funct3 110) -> C=0 gives PCWrite=1 in BRANCH; C=1 gives PCWrite=0; beq with Zero=1 gives PCWrite=1; 3 cycles total in each case.
REQ-031 Illegal op 1111111 -> with HALT_ON_ILLEGAL=1, State=15 holds for 10+ cycles with all enables 0; asserting reset returns State to 0. With HALT_ON_ILLEGAL=0 -> DECODE gives Retire=1, then FETCH.
REQ-032 Assert reset while in MEMWRITE -> MemWrite=0 in that cycle, State=0 on the next edge; sw (op 0100011) then yields sequence 0,1,2,5 with MemWrite=1 only in state 5.
